// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: one outstanding memory request, a small instruction
// queue toward decode, and redirect handling that discards in-flight results.
module instr_fetch_unit #(
  parameter int                ADDR_W   = 5,
  parameter int                Q_DEPTH  = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [31:0]       if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic [ADDR_W-1:0] if_pc_plus4
);

  localparam int PTR_W = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
  localparam int CNT_W = $clog2(Q_DEPTH + 1);
  localparam logic [CNT_W-1:0]  DEPTH = CNT_W'(Q_DEPTH);
  localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(4);

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [31:0]       instr_mem [Q_DEPTH];
  logic [ADDR_W-1:0] pc_mem    [Q_DEPTH];

  logic              ack, push, pop;
  logic [ADDR_W-1:0] redir_pc;
  logic              unused_redirect_lsb;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(Q_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // An ack only counts while a request is actually outstanding.
  assign ack                 = imem_ack & (state_q != IDLE);
  assign redir_pc            = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign unused_redirect_lsb = ^redirect_pc[1:0];
  assign push                = ack & (state_q == REQ) & ~redirect;
  assign pop                 = if_valid & if_ready & ~redirect;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    head_d     = pop  ? ptr_inc(head_q) : head_q;
    tail_d     = push ? ptr_inc(tail_q) : tail_q;
    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
    if (push) fetch_pc_d = req_addr_q + STEP;

    case (state_q)
      IDLE: begin
        if (!redirect && (count_q < DEPTH)) begin
          state_d    = REQ;
          req_addr_d = fetch_pc_q;
        end
      end
      REQ: begin
        if (redirect) begin
          // A completing request frees the bus, so the new stream can start at once.
          state_d = ack ? REQ : DROP;
          if (ack) req_addr_d = redir_pc;
        end else if (ack) begin
          if (count_d < DEPTH) req_addr_d = req_addr_q + STEP;
          else                 state_d    = IDLE;
        end
      end
      DROP: begin
        if (!redirect && ack) begin
          state_d    = REQ;
          req_addr_d = fetch_pc_q;
        end
      end
      default: state_d = IDLE;
    endcase

    if (redirect) begin
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
      fetch_pc_d = redir_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      count_q    <= '0;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[tail_q] <= imem_rdata;
      pc_mem[tail_q]    <= req_addr_q;
    end
  end

  // Head outputs are forced to zero when empty so reset and flush show clean values.
  assign imem_req    = (state_q != IDLE);
  assign imem_addr   = req_addr_q;
  assign if_valid    = (count_q != '0);
  assign if_instr    = if_valid ? instr_mem[head_q] : '0;
  assign if_pc       = if_valid ? pc_mem[head_q] : '0;
  assign if_pc_plus4 = if_valid ? pc_mem[head_q] + STEP : '0;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized scoreboard bench for instr_fetch_unit: the bench plays the memory,
// predicts the delivered instruction stream, and a monitor checks decode-side output.
module tb_instr_fetch_unit;

  localparam int AW = 5;
  localparam int NW = 1 << (AW - 2);
  localparam logic [AW-1:0] RST_PC = '0;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [31:0]   instr;
  } item_t;

  logic          clk, rst_n;
  logic          imem_req, imem_ack;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata;
  logic          redirect;
  logic [AW-1:0] redirect_pc;
  logic          if_valid, if_ready;
  logic [31:0]   if_instr;
  logic [AW-1:0] if_pc, if_pc_plus4;

  instr_fetch_unit #(.ADDR_W(AW), .Q_DEPTH(2), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
    .if_pc(if_pc), .if_pc_plus4(if_pc_plus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  item_t         sb[$];
  item_t         e;
  logic [31:0]   mem_a [NW];
  int            checks = 0;
  int            errors = 0;
  int            pops = 0;
  bit            busy, stale, prev_wait, st_prev;
  int            lat;
  logic [AW-1:0] exp_pc, prev_addr, st_pc;
  logic [31:0]   st_instr;

  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    return mem_a[a[AW-1:2]];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    exp_pc    = RST_PC;
    stale     = 1'b0;
    busy      = 1'b0;
    prev_wait = 1'b0;
    lat       = 0;
  endtask

  // One clock of stimulus plus the reference model's view of what that edge does.
  task automatic do_cycle(input int rdy_pct, input int redir_pct, input int max_lat, input bit hold_ack);
    bit            req, ack_e, do_push, do_flush;
    logic [AW-1:0] addr;
    item_t         it;
    @(negedge clk);
    if_ready    = (int'($urandom_range(99)) < rdy_pct);
    redirect    = (int'($urandom_range(99)) < redir_pct);
    redirect_pc = AW'($urandom);
    req  = imem_req;
    addr = imem_addr;
    if (req) begin
      if (!busy) begin
        busy = 1'b1;
        lat  = int'($urandom_range(32'(max_lat)));
      end
      imem_ack = !hold_ack && (lat == 0);
      if (!imem_ack && lat > 0) lat--;
    end else begin
      imem_ack = 1'($urandom_range(1));
    end
    imem_rdata = mem_word(addr);
    ack_e = req && imem_ack;

    if (prev_wait) check("imem_hold", {req, addr}, {1'b1, prev_addr});
    prev_wait = req && !ack_e;
    prev_addr = addr;

    do_push  = 1'b0;
    do_flush = 1'b0;
    if (redirect) begin
      do_flush = 1'b1;
      exp_pc   = {redirect_pc[AW-1:2], 2'b00};
      if (req && !ack_e) stale = 1'b1;
    end else if (ack_e) begin
      if (stale) begin
        stale = 1'b0;
      end else begin
        check("fetch_addr", addr, exp_pc);
        it      = '{pc: exp_pc, instr: mem_word(exp_pc)};
        do_push = 1'b1;
        exp_pc  = exp_pc + AW'(4);
      end
    end
    if (ack_e) busy = 1'b0;

    @(posedge clk);
    #1;
    if (do_flush)     sb.delete();
    else if (do_push) sb.push_back(it);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_imem_req"}, imem_req, 1'b0);
    check({tag, "_if_valid"}, if_valid, 1'b0);
    check({tag, "_if_instr"}, if_instr, 32'h0);
    check({tag, "_if_pc"}, if_pc, '0);
    check({tag, "_if_pc_plus4"}, if_pc_plus4, '0);
  endtask

  task automatic mid_reset();
    for (int i = 0; i < 8 && !imem_req; i++) do_cycle(100, 0, 3, 1'b1);
    do_cycle(100, 0, 3, 1'b1);
    check("req_before_rst", imem_req, 1'b1);
    @(negedge clk);
    redirect = 1'b0;
    imem_ack = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    imem_ack   = 1'b1;
    imem_rdata = $urandom;
    @(negedge clk);
    rst_n    = 1'b1;
    imem_ack = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check("midrst_first_req", imem_req, 1'b1);
    check("midrst_first_addr", imem_addr, RST_PC);
    check("midrst_if_valid", if_valid, 1'b0);
  endtask

  // Monitor: decoupled from stimulus, pops the scoreboard on every accepted head.
  always begin
    @(negedge clk);
    #2;
    if (!rst_n) begin
      st_prev = 1'b0;
    end else begin
      check("if_valid", if_valid, 64'(sb.size() != 0));
      if (st_prev) check("stall_hold", {if_valid, if_pc, if_instr}, {1'b1, st_pc, st_instr});
      st_prev  = if_valid && !if_ready && !redirect;
      st_pc    = if_pc;
      st_instr = if_instr;
      if (if_valid && if_ready && !redirect && sb.size() > 0) begin
        e = sb.pop_front();
        check("if_pc", if_pc, e.pc);
        check("if_instr", if_instr, e.instr);
        check("if_pc_plus4", if_pc_plus4, AW'(e.pc + AW'(4)));
        pops++;
      end
    end
  end

  initial begin
    int p0;
    rst_n       = 1'b0;
    imem_ack    = 1'b1;
    imem_rdata  = '0;
    redirect    = 1'b0;
    redirect_pc = '0;
    if_ready    = 1'b0;
    foreach (mem_a[i]) mem_a[i] = $urandom;
    model_reset();
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    #1;
    check_reset_outputs("rst_edge");
    @(negedge clk);
    rst_n    = 1'b1;
    imem_ack = 1'b0;
    @(posedge clk);
    #1;
    check("first_req", imem_req, 1'b1);
    check("first_addr", imem_addr, RST_PC);

    // Zero-latency memory, decode always ready: one instruction per cycle, PC wraps.
    repeat (4) do_cycle(100, 0, 0, 1'b0);
    p0 = pops;
    repeat (16) do_cycle(100, 0, 0, 1'b0);
    check("throughput", 64'(pops - p0), 64'd16);

    // Decode stalled: queue fills, request stops.
    repeat (6) do_cycle(0, 0, 0, 1'b0);
    check("fill_idle_req", imem_req, 1'b0);
    repeat (6) do_cycle(100, 0, 0, 1'b0);

    repeat (300) do_cycle(50, 10, 3, 1'b0);
    repeat (300) do_cycle(70, 25, 0, 1'b0);
    mid_reset();
    repeat (300) do_cycle(80, 5, 4, 1'b0);

    repeat (10) do_cycle(100, 0, 0, 1'b0);
    p0 = pops;
    repeat (12) do_cycle(100, 0, 0, 1'b0);
    check("drain_throughput", 64'(pops - p0), 64'd12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
